// File: rtl/llc_pkg.sv
// Shared definitions for the LLC rig: gate FSM encoding, default widths and
// the fixed-point scaling used for current words.
package llc_pkg;

  localparam int unsigned CntWDefault = 16;
  localparam int unsigned IwDefault   = 48;
  localparam int unsigned FracQ       = 20;
  localparam longint      FixOne      = longint'(1) << FracQ;

  typedef enum logic [2:0] {
    StIdle,
    StDead1,
    StOn1,
    StDead0,
    StOn0,
    StTrip
  } state_e;

  function automatic logic is_run(state_e s);
    return s inside {StDead1, StOn1, StDead0, StOn0};
  endfunction

endpackage

// File: rtl/llc_ocp_cmp.sv
// Registered overcurrent comparator: oc = |ir| > ilimit, negative limits clamp to 0.
module llc_ocp_cmp
  import llc_pkg::*;
#(
  parameter int unsigned IW = IwDefault
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic signed [IW-1:0] ir,
  input  logic signed [IW-1:0] ilimit,
  output logic                 oc
);

  // One extra bit so that -ilimit never overflows.
  logic signed [IW:0] ir_x;
  logic signed [IW:0] lim_x;
  logic signed [IW:0] lim_neg;

  assign ir_x    = {ir[IW-1], ir};
  assign lim_x   = ilimit[IW-1] ? '0 : {1'b0, ilimit};
  assign lim_neg = -lim_x;

  always_ff @(posedge Clk) begin
    if (reset) begin
      oc <= 1'b0;
    end else begin
      oc <= (ir_x > lim_x) || (ir_x < lim_neg);
    end
  end

endmodule

// File: rtl/llc_gate_gen.sv
// Half-bridge gate generator: complementary G0/G1 with dead time, soft-start
// sweep of the half-period and a latched overcurrent trip.
module llc_gate_gen
  import llc_pkg::*;
#(
  parameter int unsigned CNT_W   = CntWDefault,
  parameter int unsigned IW      = IwDefault,
  parameter int unsigned SS_STEP = 1
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     half_period,
  input  logic [CNT_W-1:0]     dead_time,
  input  logic [CNT_W-1:0]     ss_start,
  input  logic signed [IW-1:0] ir,
  input  logic signed [IW-1:0] ilimit,
  input  logic                 trip_clr,
  output logic                 G0,
  output logic                 G1,
  output logic                 running,
  output logic                 tripped,
  output logic [CNT_W-1:0]     cur_half
);

  localparam logic [CNT_W-1:0] SsStep = CNT_W'(SS_STEP);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] dt_q;
  logic             oc;

  logic [CNT_W-1:0] hp_eff;
  logic [CNT_W-1:0] entry_half;
  logic [CNT_W-1:0] ch_excess;
  logic [CNT_W-1:0] next_half;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic             half_end;
  logic             dead_done;
  logic             dt_zero;

  llc_ocp_cmp #(
    .IW(IW)
  ) u_ocp (
    .Clk    (Clk),
    .reset  (reset),
    .ir     (ir),
    .ilimit (ilimit),
    .oc     (oc)
  );

  assign hp_eff     = (half_period == '0) ? CNT_W'(1) : half_period;
  assign entry_half = (ss_start > hp_eff) ? ss_start : hp_eff;

  // Soft-start step toward the target, never undershooting it; a larger
  // target is adopted immediately.
  assign ch_excess = cur_half - hp_eff;
  assign next_half = ((cur_half > hp_eff) && (ch_excess > SsStep)) ? cur_half - SsStep : hp_eff;

  assign cnt_inc   = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign cnt_sat   = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
  assign half_end  = cnt_inc >= {1'b0, cur_half};
  assign dead_done = cnt_inc >= {1'b0, dt_q};
  assign dt_zero   = (dead_time == '0);

  assign running = is_run(state_q);

  // Gates follow the state of the cycle just ended, so every half keeps its
  // exact length and a gate edge never coincides with the other gate's rise.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dt_q     <= '0;
      cur_half <= '0;
      tripped  <= 1'b0;
      G0       <= 1'b0;
      G1       <= 1'b0;
    end else if (oc) begin
      state_q <= StTrip;
      tripped <= 1'b1;
      cnt_q   <= '0;
      G0      <= 1'b0;
      G1      <= 1'b0;
    end else if (state_q == StTrip) begin
      G0 <= 1'b0;
      G1 <= 1'b0;
      if (trip_clr && !enable) begin
        state_q <= StIdle;
        tripped <= 1'b0;
      end
    end else if (!enable) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      G0      <= 1'b0;
      G1      <= 1'b0;
    end else if (state_q == StIdle) begin
      cur_half <= entry_half;
      dt_q     <= dead_time;
      cnt_q    <= '0;
      state_q  <= dt_zero ? StOn1 : StDead1;
      G0       <= 1'b0;
      G1       <= 1'b0;
    end else begin
      G1 <= (state_q == StOn1);
      G0 <= (state_q == StOn0);
      if (half_end) begin
        cnt_q <= '0;
        dt_q  <= dead_time;
        unique case (state_q)
          StDead1, StOn1: state_q <= dt_zero ? StOn0 : StDead0;
          StDead0, StOn0: begin
            state_q  <= dt_zero ? StOn1 : StDead1;
            cur_half <= next_half;
          end
          default: state_q <= StIdle;
        endcase
      end else begin
        cnt_q <= cnt_sat;
        unique case (state_q)
          StDead1: if (dead_done) state_q <= StOn1;
          StDead0: if (dead_done) state_q <= StOn0;
          StOn1, StOn0: state_q <= state_q;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_llc_gate_gen.sv
// Directed and randomized bench for llc_gate_gen against a cycle-position model.
module tb_llc_gate_gen;
  import llc_pkg::*;

  localparam int unsigned CW  = 16;
  localparam int unsigned IWL = 48;
  localparam int          SS  = 10;
  localparam longint      One = longint'(1) << FracQ;

  logic                  Clk = 1'b0;
  logic                  reset, enable, trip_clr;
  logic [CW-1:0]         half_period, dead_time, ss_start;
  logic signed [IWL-1:0] ir, ilimit;
  logic                  G0, G1, running, tripped;
  logic [CW-1:0]         cur_half;

  int checks = 0;
  int errors = 0;

  // Model: run/trip flags, which half (1 = G1 half), position inside it.
  bit m_tripped, m_run, m_oc, m_g0, m_g1;
  int m_half, m_pos, m_ch, m_dt;

  always #5 Clk = ~Clk;

  llc_gate_gen #(
    .CNT_W  (CW),
    .IW     (IWL),
    .SS_STEP(SS)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .enable     (enable),
    .half_period(half_period),
    .dead_time  (dead_time),
    .ss_start   (ss_start),
    .ir         (ir),
    .ilimit     (ilimit),
    .trip_clr   (trip_clr),
    .G0         (G0),
    .G1         (G1),
    .running    (running),
    .tripped    (tripped),
    .cur_half   (cur_half)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    longint irl, lim;
    int     hp;
    bit     oc_now;
    irl    = longint'(ir);
    lim    = longint'(ilimit);
    if (lim < 0) lim = 0;
    oc_now = (irl > lim) || (irl < -lim);
    hp     = (half_period == 0) ? 1 : int'(half_period);
    if (reset) begin
      m_tripped = 0; m_run = 0; m_g0 = 0; m_g1 = 0; m_ch = 0; m_pos = 0; oc_now = 0;
    end else if (m_oc) begin
      m_tripped = 1; m_run = 0; m_g0 = 0; m_g1 = 0;
    end else if (m_tripped) begin
      m_g0 = 0; m_g1 = 0;
      if (trip_clr && !enable) m_tripped = 0;
    end else if (!enable) begin
      m_run = 0; m_g0 = 0; m_g1 = 0;
    end else if (!m_run) begin
      m_run = 1; m_ch = (int'(ss_start) > hp) ? int'(ss_start) : hp;
      m_half = 1; m_pos = 0; m_dt = int'(dead_time); m_g0 = 0; m_g1 = 0;
    end else begin
      m_g1 = (m_half == 1) && (m_pos >= m_dt);
      m_g0 = (m_half == 0) && (m_pos >= m_dt);
      m_pos++;
      if (m_pos >= m_ch) begin
        if (m_half == 0) m_ch = (m_ch - SS > hp) ? m_ch - SS : hp;
        m_half = 1 - m_half;
        m_pos  = 0;
        m_dt   = int'(dead_time);
      end
    end
    m_oc = oc_now;
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check("G0", G0, m_g0);
    check("G1", G1, m_g1);
    check("running", running, m_run);
    check("tripped", tripped, m_tripped);
    check("cur_half", cur_half, m_ch);
    check("no_overlap", G0 & G1, 0);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_gate(input bit which, input int bound);
    int k = 0;
    while (!(which ? m_g1 : m_g0) && k < bound) begin
      cycle();
      k++;
    end
    check(which ? "wait_g1" : "wait_g0", which ? G1 : G0, 1);
  endtask

  task automatic restart();
    enable = 0;
    run(1);
    enable = 1;
  endtask

  initial begin
    int n;
    longint v;
    reset = 1; enable = 0; trip_clr = 0; ir = '0; ilimit = 5 * One;
    half_period = 100; dead_time = 5; ss_start = 100;
    m_tripped = 0; m_run = 0; m_oc = 0; m_g0 = 0; m_g1 = 0;
    m_half = 1; m_pos = 0; m_ch = 0; m_dt = 0;
    run(3);
    reset = 0;
    run(2);

    // Steady state: first rise after dt+1 edges past the sampling edge.
    enable = 1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!G1 && n < 300);
    check("first_rise_edges", n, 7);
    n = 0;
    while (G1 && n < 300) begin
      n++;
      cycle();
    end
    check("g1_high_len", n, 95);
    run(400);

    // Soft start 200 -> 100 in steps of SS.
    restart();
    ss_start = 200;
    run(3400);
    check("ss_settled", cur_half, 100);

    // Overcurrent, positive then negative.
    for (int rep = 0; rep < 2; rep++) begin
      ss_start = 100;
      restart();
      wait_gate(1, 400);
      ir = (rep == 0) ? 6 * One : -6 * One;
      cycle();
      ir = '0;
      cycle();
      check("trip_gates", {G1, G0}, 2'b00);
      check("trip_flag", tripped, 1);
      run(10);
      trip_clr = 1;
      run(2);
      check("trip_clr_enabled", tripped, 1);
      enable = 0;
      run(1);
      check("trip_cleared", tripped, 0);
      trip_clr = 0;
      enable = 1;
      run(40);
    end

    // Zero dead time, then fully dead halves.
    half_period = 20; dead_time = 0; ss_start = 0;
    restart();
    run(100);
    half_period = 100; dead_time = 100;
    restart();
    run(300);
    check("dead_running", running, 1);

    // Disable and reset during ON0.
    half_period = 50; dead_time = 5;
    restart();
    wait_gate(0, 300);
    enable = 0;
    cycle();
    check("disable_g0", G0, 0);
    check("disable_hold", cur_half, 50);
    run(3);
    enable = 1;
    run(60);
    wait_gate(0, 300);
    reset = 1;
    cycle();
    check("reset_cur_half", cur_half, 0);
    reset = 0;
    run(5);

    // Randomized segments with occasional mid-period changes and spikes.
    for (int s = 0; s < 30; s++) begin
      half_period = CW'($urandom_range(0, 40));
      dead_time   = CW'($urandom_range(0, 45));
      ss_start    = CW'($urandom_range(0, 80));
      enable      = ($urandom_range(0, 9) != 0);
      trip_clr    = ($urandom_range(0, 3) == 0);
      ilimit      = ($urandom_range(0, 4) == 0) ? -One : longint'($urandom_range(1, 8)) * One;
      n = $urandom_range(20, 150);
      for (int k = 0; k < n; k++) begin
        v = 0;
        if ($urandom_range(0, 60) == 0) begin
          v = longint'($urandom_range(0, 12)) * One;
          if ($urandom_range(0, 1) == 1) v = -v;
        end
        ir = v;
        if ($urandom_range(0, 50) == 0) dead_time = CW'($urandom_range(0, 45));
        if ($urandom_range(0, 50) == 0) half_period = CW'($urandom_range(0, 40));
        cycle();
      end
    end
    ir = '0;
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
